// File: rtl/cnn_out_pack.sv
// cnn_out_pack: window accumulate, bias, relu/shift/saturate to 8-bit
// pixels, pack into memory words and write them out via req/ack.
module cnn_out_pack #(
  parameter int DP_WIDTH     = 17,
  parameter int ACC_WIDTH    = 24,
  parameter int ADDR_WIDTH   = 19,
  parameter int MEM_DATA_BUS = 128,
  parameter int WIN_ROWS     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sw_start,
  input  logic [ADDR_WIDTH-1:0]   sw_cnn_addr_z,
  input  logic [15:0]             sw_bias,
  input  logic [3:0]              sw_shift,
  input  logic [15:0]             sw_num_out,
  input  logic                    dp_valid,
  input  logic [DP_WIDTH-1:0]     dp_res,
  output logic                    dp_ready,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_start_addr,
  output logic [4:0]              mem_size_bytes,
  output logic [MEM_DATA_BUS-1:0] mem_data,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    done
);

  localparam int BYTES = MEM_DATA_BUS / 8;
  localparam int BW = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WIN_ROWS - 1);
  localparam logic [4:0] LAST_BYTE = 5'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;

  state_t state_q, state_d;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] dp_ext;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] q;
  logic [BW-1:0] beat_q;
  logic [15:0]   bias_q;
  logic [3:0]    shift_q;
  logic [15:0]   num_q;
  logic [15:0]   pix_q;
  logic [7:0]    pix;

  logic beat_ok, last_beat, word_end;
  logic ack_ok, job_end, start_ok;
  logic busy_d, dp_ready_d, mem_req_d, done_d;

  always_comb begin
    dp_ext   = {{(ACC_WIDTH-DP_WIDTH){dp_res[DP_WIDTH-1]}}, dp_res};
    bias_ext = {{(ACC_WIDTH-16){bias_q[15]}}, bias_q};
    sum      = acc_q + dp_ext + bias_ext;
    q        = sum >>> shift_q;
    pix      = 8'd0;
    if (!sum[ACC_WIDTH-1])
      pix = (|q[ACC_WIDTH-1:8]) ? 8'hff : q[7:0];
  end

  assign beat_ok   = dp_valid & dp_ready;
  assign last_beat = beat_ok & (beat_q == LAST_BEAT);
  assign word_end  = last_beat &
                     ((mem_size_bytes == LAST_BYTE) |
                      (pix_q + 16'd1 == num_q));
  assign ack_ok    = mem_req & mem_ack;
  assign job_end   = ack_ok & (pix_q == num_q);
  assign start_ok  = sw_start & (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start_ok && sw_num_out != 16'd0)
          state_d = ACCUM;
      ACCUM:
        if (word_end) state_d = WRITE;
      WRITE:
        if (ack_ok) state_d = job_end ? IDLE : ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are the next-cycle view of the FSM, registered below.
  always_comb begin
    busy_d     = (state_d != IDLE);
    dp_ready_d = (state_d == ACCUM);
    mem_req_d  = (state_d == WRITE);
    done_d     = (start_ok && sw_num_out == 16'd0) ||
                 (state_q == WRITE && job_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      dp_ready <= 1'b0;
      mem_req  <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy     <= busy_d;
      dp_ready <= dp_ready_d;
      mem_req  <= mem_req_d;
      done     <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_start_addr <= '0;
      mem_size_bytes <= '0;
      mem_data       <= '0;
      acc_q          <= '0;
      beat_q         <= '0;
      bias_q         <= '0;
      shift_q        <= '0;
      num_q          <= '0;
      pix_q          <= '0;
    end else begin
      if (start_ok) begin
        mem_start_addr <= sw_cnn_addr_z;
        bias_q         <= sw_bias;
        shift_q        <= sw_shift;
        num_q          <= sw_num_out;
        acc_q          <= '0;
        beat_q         <= '0;
        mem_size_bytes <= '0;
        pix_q          <= '0;
        mem_data       <= '0;
      end
      if (beat_ok) begin
        if (last_beat) begin
          for (int k = 0; k < BYTES; k++)
            if (mem_size_bytes == 5'(k))
              mem_data[8*k +: 8] <= pix;
          mem_size_bytes <= mem_size_bytes + 5'd1;
          pix_q          <= pix_q + 16'd1;
          acc_q          <= '0;
          beat_q         <= '0;
        end else begin
          acc_q  <= acc_q + dp_ext;
          beat_q <= beat_q + BW'(1);
        end
      end
      if (ack_ok) begin
        mem_start_addr <= mem_start_addr + ADDR_WIDTH'(BYTES);
        mem_data       <= '0;
        mem_size_bytes <= '0;
      end
    end
  end

endmodule
